snn_input_loader: RTL and testbench

Front-end stage of the SNN digit classifier. Receives the 784-pixel binary image as 98 bytes from the UART receiver, unpacks each byte into eight 1-bit writes to the input-unit RAM (784x1), then pulses `start` to the core. It holds off further bytes until the core reports `done`. It also owns the input-RAM address mux, so the core reads the same RAM during inference.

---
 rtl/snn_pkg.sv | 22 ++
 rtl/snn_input_loader.sv | 123 ++++++++++++
 tb/tb_snn_input_loader.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/snn_pkg.sv
// Shared constants and types for the SNN digit classifier.
package snn_pkg;

    // Pixels in one binary input image (28x28).
    localparam int NUM_PIXELS = 784;

    // Address width of the 784x1 input-unit RAM.
    localparam int ADDR_IN_W  = 10;

    // Bits carried by one UART byte.
    localparam int BYTE_W     = 8;

    // Input loader control states.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_BYTE = 3'd1,
        UNPACK    = 3'd2,
        START     = 3'd3,
        RUN       = 3'd4
    } loader_state_e;

endpackage

// File: rtl/snn_input_loader.sv
// Input loader: takes the packed image byte-by-byte from the UART, writes it
// LSB-first into the 784x1 input RAM, kicks the core, then hands the RAM
// address port to the core until it reports done.
module snn_input_loader #(
    parameter int NUM_PIXELS = snn_pkg::NUM_PIXELS,  // must be a multiple of BYTE_W
    parameter int BYTE_W     = snn_pkg::BYTE_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx_rdy,
    input  logic [BYTE_W-1:0]             rx_data,
    output logic                          clr_rx_rdy,
    input  logic [snn_pkg::ADDR_IN_W-1:0] core_addr,
    input  logic                          core_done,
    output logic [snn_pkg::ADDR_IN_W-1:0] ram_addr,
    output logic                          ram_d,
    output logic                          ram_we,
    output logic                          start,
    output logic                          busy
);
    import snn_pkg::*;

    localparam int BIT_W = $clog2(BYTE_W);

    localparam logic [BIT_W-1:0]     LAST_BIT = BIT_W'(BYTE_W - 1);
    localparam logic [ADDR_IN_W-1:0] LAST_PIX = ADDR_IN_W'(NUM_PIXELS - 1);

    loader_state_e          state_q, state_d;
    logic [BYTE_W-1:0]      shift_q, shift_d;
    logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [ADDR_IN_W-1:0]   pix_cnt_q, pix_cnt_d;
    logic                   busy_q, busy_d;

    // State and datapath registers; reset discards any partial image.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            pix_cnt_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            pix_cnt_q <= pix_cnt_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state logic and state-decoded outputs, including the RAM address mux.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        pix_cnt_d  = pix_cnt_q;
        busy_d     = busy_q;
        clr_rx_rdy = 1'b0;
        ram_we     = 1'b0;
        ram_d      = 1'b0;
        start      = 1'b0;
        ram_addr   = pix_cnt_q;

        case (state_q)
            IDLE: begin
                // First byte of a new image also raises busy.
                if (rx_rdy) begin
                    shift_d    = rx_data;
                    clr_rx_rdy = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = UNPACK;
                end
            end

            WAIT_BYTE: begin
                if (rx_rdy) begin
                    shift_d    = rx_data;
                    clr_rx_rdy = 1'b1;
                    state_d    = UNPACK;
                end
            end

            UNPACK: begin
                // One pixel per cycle, LSB of the byte first.
                ram_we    = 1'b1;
                ram_d     = shift_q[0];
                shift_d   = shift_q >> 1;
                bit_cnt_d = bit_cnt_q + 1'b1;
                pix_cnt_d = pix_cnt_q + 1'b1;
                if (bit_cnt_q == LAST_BIT) begin
                    // Image length is a whole number of bytes, so the last
                    // pixel always lines up with the last bit of a byte.
                    if (pix_cnt_q == LAST_PIX) begin
                        pix_cnt_d = '0;
                        state_d   = START;
                    end else begin
                        state_d   = WAIT_BYTE;
                    end
                end
            end

            START: begin
                start    = 1'b1;
                ram_addr = core_addr;
                state_d  = RUN;
            end

            RUN: begin
                // Core owns the RAM; UART bytes wait until we are back in IDLE.
                ram_addr = core_addr;
                if (core_done) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign busy = busy_q;

endmodule

// File: tb/tb_snn_input_loader.sv
// Directed bench for snn_input_loader with a behavioural 784x1 input RAM.
module tb_snn_input_loader;

    logic       clk;
    logic       rst_n;
    logic       rx_rdy;
    logic [7:0] rx_data;
    logic       clr_rx_rdy;
    logic [9:0] core_addr;
    logic       core_done;
    logic [9:0] ram_addr;
    logic       ram_d;
    logic       ram_we;
    logic       start;
    logic       busy;

    snn_input_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_rdy     (rx_rdy),
        .rx_data    (rx_data),
        .clr_rx_rdy (clr_rx_rdy),
        .core_addr  (core_addr),
        .core_done  (core_done),
        .ram_addr   (ram_addr),
        .ram_d      (ram_d),
        .ram_we     (ram_we),
        .start      (start),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Input-unit RAM model, written on the same edges as the real RAM.
    logic mem [0:783];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_d;
    end

    // Monitor: counts writes, starts and acks; flags out-of-order addresses,
    // misplaced start pulses and multi-cycle acks.
    int wr_cnt = 0, start_cnt = 0, clr_cnt = 0;
    int addr_err = 0, start_err = 0, clr_err = 0;
    int exp_wr = 0;
    logic prev_we = 1'b0, prev_clr = 1'b0;
    logic [9:0] prev_addr = '0;
    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            exp_wr    = 0;
            prev_we   = 1'b0;
            prev_clr  = 1'b0;
            prev_addr = '0;
        end else begin
            if (ram_we) begin
                if (int'(ram_addr) != exp_wr) addr_err++;
                exp_wr = (exp_wr == 783) ? 0 : exp_wr + 1;
                wr_cnt++;
            end
            if (start) begin
                start_cnt++;
                if (!(prev_we && prev_addr == 10'd783)) start_err++;
            end
            if (clr_rx_rdy) begin
                clr_cnt++;
                if (prev_clr) clr_err++;
            end
            prev_we   = ram_we;
            prev_addr = ram_addr;
            prev_clr  = clr_rx_rdy;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Raise rx_rdy with a byte, hold it until acknowledged, then idle for gap cycles.
    task automatic send_byte(input logic [7:0] d, input int gap);
        bit got;
        got     = 1'b0;
        rx_data = d;
        rx_rdy  = 1'b1;
        for (int n = 0; n < 40 && !got; n++) begin
            #1;
            got = clr_rx_rdy;
            @(negedge clk);
        end
        rx_rdy = 1'b0;
        chk("ack_seen", int'(got), 1);
        repeat (gap) @(negedge clk);
    endtask

    task automatic wait_start(input int bound);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < bound && !seen; n++) begin
            #1;
            seen = start;
            @(negedge clk);
        end
        chk("start_seen", int'(seen), 1);
    endtask

    logic [7:0] img2 [0:97];

    // rx_rdy held high continuously; new data after every ack.
    task automatic stream(input int first, input int last);
        int idx, prev, cyc, gap_bad;
        idx = first; prev = -1; cyc = 0; gap_bad = 0;
        rx_rdy  = 1'b1;
        rx_data = img2[idx];
        while (idx <= last && cyc < 2000) begin
            #1;
            if (clr_rx_rdy) begin
                if (prev >= 0 && cyc - prev != 9) gap_bad++;
                prev = cyc;
                idx++;
            end
            @(negedge clk);
            cyc++;
            if (idx <= last) rx_data = img2[idx];
            else             rx_rdy  = 1'b0;
        end
        rx_rdy = 1'b0;
        chk("b2b_gap9", gap_bad, 0);
        chk("b2b_all_acked", idx, last + 1);
    endtask

    typedef struct {
        logic [9:0] ca;
        logic       rx;
        logic [7:0] rd;
        logic       done;
        logic [9:0] e_addr;
        logic       e_we;
        logic       e_d;
        logic       e_clr;
        logic       e_busy;
        logic       e_start;
    } vec_t;

    vec_t vecs [0:6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b_wr, b_st, b_clr, bad;

        // RUN-phase vectors, starting in RUN after the first image.
        //           ca      rx    rd     done  addr    we    d     clr   busy  start
        vecs[0] = '{10'h155, 1'b1, 8'h01, 1'b0, 10'h155, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{10'h2AA, 1'b1, 8'h01, 1'b0, 10'h2AA, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{10'h0AB, 1'b1, 8'h01, 1'b1, 10'h0AB, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{10'h155, 1'b1, 8'h01, 1'b0, 10'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{10'h155, 1'b0, 8'h01, 1'b0, 10'h000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{10'h155, 1'b0, 8'h01, 1'b1, 10'h001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{10'h155, 1'b0, 8'h01, 1'b0, 10'h002, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

        img2[0] = 8'h01;
        for (int k = 1; k < 98; k++) img2[k] = 8'(k * 37) ^ 8'h5C;

        rst_n = 1'b0; rx_rdy = 1'b0; rx_data = '0; core_addr = 10'h3C3; core_done = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_clr",   int'(clr_rx_rdy), 0);
        chk("rst_we",    int'(ram_we), 0);
        chk("rst_d",     int'(ram_d), 0);
        chk("rst_start", int'(start), 0);
        chk("rst_busy",  int'(busy), 0);
        chk("rst_addr",  int'(ram_addr), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // core_done in IDLE is ignored.
        @(negedge clk);
        core_done = 1'b1;
        #1;
        chk("idle_done_busy", int'(busy), 0);
        @(negedge clk);
        core_done = 1'b0;
        #1;
        chk("idle_done_busy_after", int'(busy), 0);
        chk("idle_done_addr", int'(ram_addr), 0);
        @(negedge clk);

        // Image 1: 98 x 0xA5, one byte every 20 cycles.
        b_wr = wr_cnt; b_st = start_cnt; b_clr = clr_cnt;
        for (int k = 0; k < 98; k++) send_byte(8'hA5, (k == 97) ? 0 : 19);
        chk("img1_start_early", start_cnt - b_st, 0);
        wait_start(20);
        chk("img1_acks",     clr_cnt - b_clr, 98);
        chk("img1_writes",   wr_cnt - b_wr, 784);
        chk("img1_starts",   start_cnt - b_st, 1);
        chk("img1_busy_run", int'(busy), 1);
        bad = 0;
        for (int i = 0; i < 784; i++) if (mem[i] !== ((8'hA5 >> (i % 8)) & 8'h01) != 0) bad++;
        chk("img1_ram_bad", bad, 0);

        // RUN mux, core_done with rx_rdy, then start of image 2.
        b_wr = wr_cnt; b_st = start_cnt; b_clr = clr_cnt;
        for (int i = 0; i < 7; i++) begin
            core_addr = vecs[i].ca;
            rx_rdy    = vecs[i].rx;
            rx_data   = vecs[i].rd;
            core_done = vecs[i].done;
            #1;
            chk($sformatf("vec%0d_addr", i),  int'(ram_addr),   int'(vecs[i].e_addr));
            chk($sformatf("vec%0d_we", i),    int'(ram_we),     int'(vecs[i].e_we));
            chk($sformatf("vec%0d_d", i),     int'(ram_d),      int'(vecs[i].e_d));
            chk($sformatf("vec%0d_clr", i),   int'(clr_rx_rdy), int'(vecs[i].e_clr));
            chk($sformatf("vec%0d_busy", i),  int'(busy),       int'(vecs[i].e_busy));
            chk($sformatf("vec%0d_start", i), int'(start),      int'(vecs[i].e_start));
            @(negedge clk);
        end
        core_done = 1'b0;

        // Image 2: remaining 97 bytes back-to-back.
        stream(1, 97);
        wait_start(30);
        chk("img2_acks",   clr_cnt - b_clr, 98);
        chk("img2_writes", wr_cnt - b_wr, 784);
        chk("img2_starts", start_cnt - b_st, 1);
        bad = 0;
        for (int i = 0; i < 784; i++) if (mem[i] !== img2[i / 8][i % 8]) bad++;
        chk("img2_ram_bad", bad, 0);

        // Image 3: 50 zero bytes, reset mid-load, then 98 x 0xFF.
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        for (int k = 0; k < 50; k++) send_byte(8'h00, 2);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy",  int'(busy), 0);
        chk("midrst_we",    int'(ram_we), 0);
        chk("midrst_start", int'(start), 0);
        chk("midrst_addr",  int'(ram_addr), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        b_wr = wr_cnt; b_st = start_cnt;
        for (int k = 0; k < 97; k++) send_byte(8'hFF, 2);
        chk("img3_no_early_start", start_cnt - b_st, 0);
        send_byte(8'hFF, 0);
        wait_start(20);
        chk("img3_writes", wr_cnt - b_wr, 784);
        chk("img3_starts", start_cnt - b_st, 1);
        bad = 0;
        for (int i = 0; i < 784; i++) if (mem[i] !== 1'b1) bad++;
        chk("img3_ram_bad", bad, 0);

        chk("mon_addr_order", addr_err, 0);
        chk("mon_start_after_783", start_err, 0);
        chk("mon_ack_one_cycle", clr_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
